bp_fe_instr_queue: RTL

Buffers fetched instruction words between the front-end fetch stage and the decode stage. Accepts 64-bit fetch beats carrying one or two 32-bit RV64 instructions, splits them into per-instruction entries tagged with their PC, and presents one `rv64_instr_s` per cycle to decode under a valid/yumi handshake. Supports single-cycle flush on redirect.

---
 rtl/bp_fe_instr_queue_pkg.sv | 36 +++
 rtl/bp_fe_instr_queue_mem.sv | 36 +++
 rtl/bp_fe_instr_queue.sv | 102 ++++++++++
 3 files changed

// File: rtl/bp_fe_instr_queue_pkg.sv
// rtl/bp_fe_instr_queue_pkg.sv - shared RV64 and front-end queue types
// Contents:
//   rv64_instr_width_gp          : width of one RV64 instruction word
//   rv64_instr_s                 : packed instruction word, R-type field view
//   rv64_is_illegal()            : true when the encoding is not a 32-bit one
//   BP_FE_DECLARE_QUEUE_ENTRY_S  : macro declaring {pc, instr} for a given PC width
package bp_fe_instr_queue_pkg;

    localparam int rv64_instr_width_gp = 32;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } rv64_instr_s;

    localparam logic [1:0] rv64_uncompressed_gp = 2'b11;

    // Anything whose low opcode bits are not 2'b11 is a compressed or
    // unsupported encoding from the point of view of this front end.
    function automatic logic rv64_is_illegal(input rv64_instr_s instr);
        return instr.opcode[1:0] != rv64_uncompressed_gp;
    endfunction

endpackage

`ifndef BP_FE_DECLARE_QUEUE_ENTRY_S
`define BP_FE_DECLARE_QUEUE_ENTRY_S(vaddr_width_mp) \
    typedef struct packed { \
        logic [vaddr_width_mp-1:0] pc; \
        rv64_instr_s               instr; \
    } bp_fe_queue_entry_s
`endif

// File: rtl/bp_fe_instr_queue_mem.sv
// rtl/bp_fe_instr_queue_mem.sv - 2-write/1-read register array for the instruction queue
// Ports:
//   clk_i                : clock
//   i_w0_v / i_w0_data   : write port 0, writes entry i_waddr
//   i_w1_v / i_w1_data   : write port 1, writes entry i_waddr+1 (wraps modulo els_p)
//   i_waddr              : base write index
//   i_raddr / o_rdata    : asynchronous read port
module bp_fe_instr_queue_mem #(
    parameter  int width_p = 71,
    parameter  int els_p   = 8,
    localparam int ptr_w   = $clog2(els_p)
) (
    input  logic               clk_i,
    input  logic               i_w0_v,
    input  logic               i_w1_v,
    input  logic [ptr_w-1:0]   i_waddr,
    input  logic [width_p-1:0] i_w0_data,
    input  logic [width_p-1:0] i_w1_data,
    input  logic [ptr_w-1:0]   i_raddr,
    output logic [width_p-1:0] o_rdata
);

    logic [width_p-1:0] r_mem [els_p];
    logic [ptr_w-1:0]   w_waddr1;

    // els_p is a power of two, so the natural pointer overflow is the wrap.
    assign w_waddr1 = i_waddr + ptr_w'(1);

    always_ff @(posedge clk_i) begin
        if (i_w0_v) r_mem[i_waddr]  <= i_w0_data;
        if (i_w1_v) r_mem[w_waddr1] <= i_w1_data;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/bp_fe_instr_queue.sv
// rtl/bp_fe_instr_queue.sv - fetch-to-decode instruction queue with beat splitting and flush
// Ports:
//   clk_i, reset_i         : clock, synchronous active-high reset
//   flush_i                : redirect, empties the queue at the next edge
//   fetch_v_i/fetch_ready_o: fetch beat handshake
//   fetch_pc_i, fetch_data_i : beat PC (word aligned) and two instruction words
//   instr_v_o/instr_yumi_i : decode valid/yumi handshake
//   instr_o, instr_pc_o, instr_illegal_o : head entry
//   count_o                : occupancy
module bp_fe_instr_queue
    import bp_fe_instr_queue_pkg::*;
#(
    parameter int vaddr_width_p = 39,
    parameter int els_p         = 8
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         flush_i,
    input  logic                         fetch_v_i,
    output logic                         fetch_ready_o,
    input  logic [vaddr_width_p-1:0]     fetch_pc_i,
    input  logic [63:0]                  fetch_data_i,
    output logic                         instr_v_o,
    output rv64_instr_s                  instr_o,
    output logic [vaddr_width_p-1:0]     instr_pc_o,
    output logic                         instr_illegal_o,
    input  logic                         instr_yumi_i,
    output logic [$clog2(els_p+1)-1:0]   count_o
);

    localparam int ptr_w = $clog2(els_p);
    localparam int cnt_w = $clog2(els_p+1);
    // Ready means at least two free slots, i.e. count <= els_p-2.
    localparam logic [cnt_w-1:0] ready_max_lp = cnt_w'(els_p - 2);

    `BP_FE_DECLARE_QUEUE_ENTRY_S(vaddr_width_p);

    logic [ptr_w-1:0]   r_rptr;
    logic [ptr_w-1:0]   r_wptr;
    logic [cnt_w-1:0]   r_count;

    logic               w_enq;
    logic               w_two;
    logic               w_deq;
    logic [cnt_w-1:0]   w_enq_n;
    bp_fe_queue_entry_s w_wdata0;
    bp_fe_queue_entry_s w_wdata1;
    bp_fe_queue_entry_s w_head;

    assign fetch_ready_o = (r_count <= ready_max_lp);
    assign instr_v_o     = (r_count != '0);
    assign count_o       = r_count;

    assign w_enq   = fetch_v_i & fetch_ready_o & ~flush_i;
    // A beat starting at an even word carries two instructions.
    assign w_two   = w_enq & ~fetch_pc_i[2];
    assign w_deq   = instr_yumi_i & instr_v_o & ~flush_i;
    assign w_enq_n = w_two ? cnt_w'(2) : (w_enq ? cnt_w'(1) : '0);

    assign w_wdata0 = {fetch_pc_i, fetch_pc_i[2] ? fetch_data_i[63:32] : fetch_data_i[31:0]};
    assign w_wdata1 = {fetch_pc_i + vaddr_width_p'(4), fetch_data_i[63:32]};

    always_ff @(posedge clk_i) begin
        if (reset_i | flush_i) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) r_wptr <= r_wptr + (w_two ? ptr_w'(2) : ptr_w'(1));
            if (w_deq) r_rptr <= r_rptr + ptr_w'(1);
            r_count <= r_count + w_enq_n - cnt_w'(w_deq);
        end
    end

    bp_fe_instr_queue_mem #(
        .width_p ($bits(bp_fe_queue_entry_s)),
        .els_p   (els_p)
    ) mem (
        .clk_i     (clk_i),
        .i_w0_v    (w_enq),
        .i_w1_v    (w_two),
        .i_waddr   (r_wptr),
        .i_w0_data (w_wdata0),
        .i_w1_data (w_wdata1),
        .i_raddr   (r_rptr),
        .o_rdata   (w_head)
    );

    assign instr_o         = w_head.instr;
    assign instr_pc_o      = w_head.pc;
    assign instr_illegal_o = rv64_is_illegal(w_head.instr);

`ifndef SYNTHESIS
    a_yumi_without_valid: assert property (@(posedge clk_i) disable iff (reset_i)
        instr_yumi_i |-> instr_v_o);
    a_pc_misaligned: assert property (@(posedge clk_i) disable iff (reset_i)
        w_enq |-> (fetch_pc_i[1:0] == 2'b00));
    a_count_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
        r_count <= cnt_w'(els_p));
`endif

endmodule
